// File: rtl/pucch_ncs_extract_pkg.sv
// pucch_pkg: FSM state type, sizing constants and the mod-12 reduction shared by pucch_ncs_extract.
package pucch_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SKIP, COLLECT, DONE} ncs_state_t;
  localparam int NSLOT_MAX = 160;
  localparam int NCS_BITS = 8;
  localparam int CINIT_W = 31;
  localparam int CS_MOD = 12;
  // Long division by conditional subtraction of 12*2^k, k=4..0; exact for any s < 384.
  function automatic logic [3:0] cs_mod(input logic [8:0] s);
    logic [8:0] r;
    r = s;
    for (int k = 4; k >= 0; k--)
      if (r >= 9'(CS_MOD << k)) r = r - 9'(CS_MOD << k);
    return r[3:0];
  endfunction
endpackage

// File: rtl/pucch_ncs_extract_pack.sv
// ncs_pack: LSB-first 8-bit packer for 1- or 8-bit generator words.
// o_grp_end flags (combinationally) the word that closes the current byte.
module ncs_pack #(
  parameter int nGenBit = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               i_valid,
  input  logic [nGenBit-1:0] i_bits,
  output logic               o_grp_end,
  output logic [7:0]         o_byte,
  output logic               o_byte_valid
);
  logic [7:0] nxt, byte_q, byte_d;
  logic       bv_q, bv_d;
  generate
    if (nGenBit == 8) begin : g_w8
      assign nxt = i_bits;
      assign o_grp_end = i_valid && !clr;
    end else begin : g_w1
      logic [7:0] acc_q, acc_d;
      logic [2:0] cnt_q, cnt_d;
      always_comb begin
        nxt = acc_q;
        nxt[cnt_q] = i_bits[0];
        acc_d = clr ? 8'd0 : (i_valid ? nxt : acc_q);
        cnt_d = clr ? 3'd0 : (i_valid ? cnt_q + 3'd1 : cnt_q);
      end
      assign o_grp_end = i_valid && !clr && cnt_q == 3'd7;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate
  always_comb begin
    byte_d = o_grp_end ? nxt : byte_q;
    bv_d = o_grp_end;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_q <= '0;
      bv_q <= 1'b0;
    end else begin
      byte_q <= byte_d;
      bv_q <= bv_d;
    end
  end
  assign o_byte = byte_q;
  assign o_byte_valid = bv_q;
endmodule

// File: rtl/pucch_ncs_extract.sv
// pucch_ncs_extract: drives a Gold c(n) generator, discards the bits of earlier slots and packs one 8-bit n_cs per symbol.
// Optional macro NCS_CYC_SHIFT_EN adds inputs i_m0/i_mcs and output o_cs = (m0 + mcs + n_cs) mod 12.
module pucch_ncs_extract
  import pucch_pkg::*;
#(
  parameter int nGenBit = 8,
  parameter int N_SLOT_SYMB = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [9:0]          i_nid,
  input  logic [7:0]          i_nslot,
`ifdef NCS_CYC_SHIFT_EN
  input  logic [3:0]          i_m0,
  input  logic [3:0]          i_mcs,
`endif
  output logic                o_gen_load,
  output logic                o_gen_en,
  output logic [CINIT_W-1:0]  o_gen_init,
  input  logic [nGenBit-1:0]  i_gen_bits,
  input  logic                i_gen_valid,
  output logic [NCS_BITS-1:0] o_ncs,
  output logic [3:0]          o_ncs_idx,
  output logic                o_ncs_valid,
`ifdef NCS_CYC_SHIFT_EN
  output logic [3:0]          o_cs,
`endif
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);
  ncs_state_t         state_q, state_d;
  logic [CINIT_W-1:0] init_q, init_d;
  logic [7:0]         nslot_q, nslot_d;
  logic [14:0]        skip_q, skip_d, skip_tgt;
  logic [3:0]         sym_q, sym_d, idx_q, idx_d;
  logic               err_q, err_d, done_q, done_d, grp_end;
  assign skip_tgt = 15'(N_SLOT_SYMB * int'(nslot_q) * NCS_BITS / nGenBit);
  always_comb begin
    state_d = state_q;
    init_d = init_q;
    nslot_d = nslot_q;
    skip_d = skip_q;
    sym_d = sym_q;
    idx_d = idx_q;
    err_d = 1'b0;
    done_d = state_q == DONE;
    case (state_q)
      IDLE: if (i_start) begin
        if (int'(i_nslot) >= NSLOT_MAX) err_d = 1'b1;
        else begin
          state_d = LOAD;
          init_d = {21'b0, i_nid};
          nslot_d = i_nslot;
        end
      end
      LOAD: begin
        skip_d = '0;
        sym_d = '0;
        state_d = (nslot_q == 8'd0) ? COLLECT : SKIP;
      end
      SKIP: if (i_gen_valid) begin
        skip_d = skip_q + 15'd1;
        if (skip_q == skip_tgt - 15'd1) state_d = COLLECT;
      end
      COLLECT: if (grp_end) begin
        idx_d = sym_q;
        sym_d = sym_q + 4'd1;
        if (sym_q == 4'(N_SLOT_SYMB - 1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      init_q <= '0;
      nslot_q <= '0;
      skip_q <= '0;
      sym_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q <= init_d;
      nslot_q <= nslot_d;
      skip_q <= skip_d;
      sym_q <= sym_d;
      idx_q <= idx_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
  ncs_pack #(.nGenBit(nGenBit)) u_pack (
    .clk          (clk),
    .rst          (rst),
    .clr          (state_q == LOAD),
    .i_valid      (state_q == COLLECT && i_gen_valid),
    .i_bits       (i_gen_bits),
    .o_grp_end    (grp_end),
    .o_byte       (o_ncs),
    .o_byte_valid (o_ncs_valid)
  );
  // Enable is a pure state decode so it drops with the async reset.
  assign o_gen_load = state_q == LOAD;
  assign o_gen_en = state_q == LOAD || state_q == SKIP || state_q == COLLECT;
  assign o_gen_init = init_q;
  assign o_ncs_idx = idx_q;
  assign o_busy = state_q != IDLE;
  assign o_done = done_q;
  assign o_err = err_q;
`ifdef NCS_CYC_SHIFT_EN
  logic [3:0] m0_q, m0_d, mcs_q, mcs_d;
  always_comb begin
    m0_d = (state_q == IDLE && i_start) ? i_m0 : m0_q;
    mcs_d = (state_q == IDLE && i_start) ? i_mcs : mcs_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_q <= '0;
      mcs_q <= '0;
    end else begin
      m0_q <= m0_d;
      mcs_q <= mcs_d;
    end
  end
  assign o_cs = cs_mod(9'(m0_q) + 9'(mcs_q) + 9'(o_ncs));
`endif
endmodule

// File: tb/tb_pucch_ncs_extract.sv
// tb_pucch_ncs_extract: drives an 8-bit and a 1-bit instance from a behavioural Gold generator or counting stubs.
module tb_pucch_ncs_extract;
  logic clk = 0, rst = 0;
  logic start8 = 0, start1 = 0;
  logic [9:0] nid = 0;
  logic [7:0] nslot = 0;
  logic load8, en8, nv8, busy8, done8, err8, gv8;
  logic [30:0] init8;
  logic [7:0] ncs8, gw8;
  logic [3:0] idx8;
  logic load1, en1, nv1, busy1, done1, err1, gv1, gw1;
  logic [30:0] init1;
  logic [7:0] ncs1;
  logic [3:0] idx1;
`ifdef NCS_CYC_SHIFT_EN
  logic [3:0] m0 = 0, mcs = 0, cs8, cs1;
  logic [3:0] obs_cs[$];
`endif
  int checks = 0, errors = 0, cyc = 0, ptr8 = 0, ptr1 = 0, mode = 0, done_t = -1, load_ok = 0;
  bit phase = 0, tog = 0;
  bit gold [0:511];
  bit x1 [0:2111];
  bit x2 [0:2111];
  logic [7:0] exp_ncs[$], obs_ncs[$];
  logic [3:0] exp_idx[$], obs_idx[$];
  int obs_t[$];

  always #5 clk = ~clk;

  pucch_ncs_extract #(.nGenBit(8), .N_SLOT_SYMB(14)) dut8 (
    .clk(clk), .rst(rst), .i_start(start8), .i_nid(nid), .i_nslot(nslot),
`ifdef NCS_CYC_SHIFT_EN
    .i_m0(m0), .i_mcs(mcs), .o_cs(cs8),
`endif
    .o_gen_load(load8), .o_gen_en(en8), .o_gen_init(init8), .i_gen_bits(gw8), .i_gen_valid(gv8),
    .o_ncs(ncs8), .o_ncs_idx(idx8), .o_ncs_valid(nv8), .o_busy(busy8), .o_done(done8), .o_err(err8)
  );
  pucch_ncs_extract #(.nGenBit(1), .N_SLOT_SYMB(14)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_nid(nid), .i_nslot(nslot),
`ifdef NCS_CYC_SHIFT_EN
    .i_m0(m0), .i_mcs(mcs), .o_cs(cs1),
`endif
    .o_gen_load(load1), .o_gen_en(en1), .o_gen_init(init1), .i_gen_bits(gw1), .i_gen_valid(gv1),
    .o_ncs(ncs1), .o_ncs_idx(idx1), .o_ncs_valid(nv1), .o_busy(busy1), .o_done(done1), .o_err(err1)
  );

  // Zero-latency generators: word pointer restarts on load, advances on every valid word.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    phase <= ~phase;
    ptr8 <= load8 ? 0 : ptr8 + int'(gv8);
    ptr1 <= load1 ? 0 : ptr1 + int'(gv1);
  end
  assign gv8 = en8 && !load8 && (!tog || phase);
  assign gv1 = en1 && !load1 && (!tog || phase);
  assign gw1 = gold[ptr1];
  always_comb begin
    gw8 = (mode == 2) ? 8'hFF : 8'(ptr8);
    if (mode == 0) for (int i = 0; i < 8; i++) gw8[i] = gold[ptr8 * 8 + i];
  end

  task automatic gen_gold(input int cinit);
    for (int n = 0; n < 31; n++) begin
      x1[n] = (n == 0);
      x2[n] = cinit[n];
    end
    for (int n = 0; n + 31 < 2112; n++) begin
      x1[n + 31] = x1[n + 3] ^ x1[n];
      x2[n + 31] = x2[n + 3] ^ x2[n + 2] ^ x2[n + 1] ^ x2[n];
    end
    for (int n = 0; n < 512; n++) gold[n] = x1[n + 1600] ^ x2[n + 1600];
  endtask

  function automatic logic [7:0] gold_ncs(input int ns, input int l);
    logic [7:0] r;
    for (int m = 0; m < 8; m++) r[m] = gold[112 * ns + 8 * l + m];
    return r;
  endfunction

  task automatic run_slot(input bit s1, input int ns, input int poke);
    obs_ncs.delete(); obs_idx.delete(); obs_t.delete();
`ifdef NCS_CYC_SHIFT_EN
    obs_cs.delete();
`endif
    done_t = -1;
    nslot = 8'(ns);
    @(negedge clk); start8 = !s1; start1 = s1;
    @(negedge clk); start8 = 0; start1 = 0;
    load_ok = int'(s1 ? load1 : load8);
    for (int k = 0; k < 3000 && done_t < 0; k++) begin
      @(negedge clk);
      if (s1 ? nv1 : nv8) begin
        obs_ncs.push_back(s1 ? ncs1 : ncs8);
        obs_idx.push_back(s1 ? idx1 : idx8);
        obs_t.push_back(cyc);
`ifdef NCS_CYC_SHIFT_EN
        obs_cs.push_back(s1 ? cs1 : cs8);
`endif
      end
      if (s1 ? done1 : done8) done_t = cyc;
      start8 = (k == poke) && !s1;
      start1 = (k == poke) && s1;
    end
    start8 = 0; start1 = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({load8, en8, nv8, busy8, done8, err8, init8, ncs8, idx8} !== '0) begin
      errors++; $display("FAIL reset8: outputs=%h, expected all 0", {load8, en8, nv8, busy8, done8, err8, init8, ncs8, idx8});
    end
    checks++;
    if ({load1, en1, nv1, busy1, done1, err1, init1, ncs1, idx1} !== '0) begin
      errors++; $display("FAIL reset1: outputs=%h, expected all 0", {load1, en1, nv1, busy1, done1, err1, init1, ncs1, idx1});
    end
`ifdef NCS_CYC_SHIFT_EN
    checks++;
    if (cs8 !== 4'd0) begin errors++; $display("FAIL reset_cs: got %0d expected 0", cs8); end
`endif
    rst = 1;
  endtask

  task automatic test_gold8();
    logic [7:0] e; logic [3:0] ei; bit bad;
    mode = 0; tog = 0; nid = 10'd512; gen_gold(512);
    for (int l = 0; l < 14; l++) begin exp_ncs.push_back(gold_ncs(3, l)); exp_idx.push_back(4'(l)); end
    run_slot(0, 3, -1);
    checks++;
    if (load_ok != 1 || done_t < 0 || init8 !== 31'd512) begin
      errors++; $display("FAIL gold8_run: load=%0d done_t=%0d init=%0d, expected load=1 done seen init=512", load_ok, done_t, init8);
    end
    checks++;
    if (ptr8 != 56) begin errors++; $display("FAIL gold8_words: consumed %0d, expected 56", ptr8); end
    for (int l = 0; l < 14; l++) begin
      e = exp_ncs.pop_front(); ei = exp_idx.pop_front(); checks++;
      if (l >= obs_ncs.size() || obs_ncs[l] !== e || obs_idx[l] !== ei) begin
        errors++; $display("FAIL gold8_ncs l=%0d: got %0d/idx %0d, expected %0d/idx %0d", l, obs_ncs[l], obs_idx[l], e, ei);
      end
    end
    bad = obs_t.size() != 14;
    for (int l = 1; l < obs_t.size(); l++) bad |= obs_t[l] - obs_t[l - 1] != 1;
    checks++;
    if (bad || done_t != obs_t[obs_t.size() - 1] + 1) begin
      errors++; $display("FAIL gold8_timing: %0d strobes, done at %0d, expected 14 consecutive then done +1", obs_t.size(), done_t);
    end
  endtask

  task automatic test_gold1();
    logic [7:0] e; logic [3:0] ei; bit bad;
    mode = 0; tog = 0; nid = 10'd100; gen_gold(100);
    for (int l = 0; l < 14; l++) begin exp_ncs.push_back(gold_ncs(2, l)); exp_idx.push_back(4'(l)); end
    run_slot(1, 2, -1);
    checks++;
    if (load_ok != 1 || done_t < 0 || ptr1 != 336) begin
      errors++; $display("FAIL gold1_run: load=%0d done_t=%0d bits=%0d, expected load=1 done seen bits=336", load_ok, done_t, ptr1);
    end
    for (int l = 0; l < 14; l++) begin
      e = exp_ncs.pop_front(); ei = exp_idx.pop_front(); checks++;
      if (l >= obs_ncs.size() || obs_ncs[l] !== e || obs_idx[l] !== ei) begin
        errors++; $display("FAIL gold1_ncs l=%0d: got %0d/idx %0d, expected %0d/idx %0d", l, obs_ncs[l], obs_idx[l], e, ei);
      end
    end
    bad = obs_t.size() != 14;
    for (int l = 1; l < obs_t.size(); l++) bad |= obs_t[l] - obs_t[l - 1] != 8;
    checks++;
    if (bad) begin errors++; $display("FAIL gold1_spacing: %0d strobes, expected 14 spaced 8 cycles", obs_t.size()); end
  endtask

  task automatic test_stub_consec(input string name, input int poke);
    logic [7:0] e; logic [3:0] ei; bit bad; int busy_seen;
    mode = 1; tog = 0;
    for (int l = 0; l < 14; l++) begin exp_ncs.push_back(8'(l)); exp_idx.push_back(4'(l)); end
    run_slot(0, 0, poke);
    checks++;
    if (load_ok != 1 || done_t < 0) begin errors++; $display("FAIL %s_run: load=%0d done_t=%0d, expected load=1 done seen", name, load_ok, done_t); end
    for (int l = 0; l < 14; l++) begin
      e = exp_ncs.pop_front(); ei = exp_idx.pop_front(); checks++;
      if (l >= obs_ncs.size() || obs_ncs[l] !== e || obs_idx[l] !== ei) begin
        errors++; $display("FAIL %s_ncs l=%0d: got %0d/idx %0d, expected %0d/idx %0d", name, l, obs_ncs[l], obs_idx[l], e, ei);
      end
    end
    bad = obs_t.size() != 14;
    for (int l = 1; l < obs_t.size(); l++) bad |= obs_t[l] - obs_t[l - 1] != 1;
    checks++;
    if (bad || done_t != obs_t[obs_t.size() - 1] + 1) begin
      errors++; $display("FAIL %s_timing: %0d strobes, done at %0d, expected 14 consecutive then done +1", name, obs_t.size(), done_t);
    end
    if (poke >= 0) begin
      busy_seen = 0;
      for (int k = 0; k < 4; k++) begin @(negedge clk); busy_seen += int'(busy8); end
      checks++;
      if (busy_seen != 0) begin errors++; $display("FAIL %s_queued: busy for %0d cycles after done, expected 0", name, busy_seen); end
    end
  endtask

  task automatic test_stub_toggle();
    logic [7:0] e; bit bad;
    mode = 1; tog = 1;
    for (int l = 0; l < 14; l++) exp_ncs.push_back(8'(14 + l));
    run_slot(0, 1, -1);
    tog = 0;
    for (int l = 0; l < 14; l++) begin
      e = exp_ncs.pop_front(); checks++;
      if (l >= obs_ncs.size() || obs_ncs[l] !== e) begin
        errors++; $display("FAIL toggle_ncs l=%0d: got %0d, expected %0d", l, obs_ncs[l], e);
      end
    end
    bad = obs_t.size() != 14 || done_t < 0;
    for (int l = 1; l < obs_t.size(); l++) bad |= obs_t[l] - obs_t[l - 1] != 2;
    checks++;
    if (bad) begin errors++; $display("FAIL toggle_spacing: %0d strobes done_t=%0d, expected 14 spaced 2 cycles", obs_t.size(), done_t); end
  endtask

  task automatic test_err();
    int errs = 0, active = 0;
    nslot = 8'd160;
    @(negedge clk); start8 = 1;
    @(negedge clk); start8 = 0;
    for (int k = 0; k < 4; k++) begin
      errs += int'(err8);
      active += int'(load8 | busy8);
      @(negedge clk);
    end
    checks++;
    if (errs != 1 || active != 0) begin
      errors++; $display("FAIL err_nslot160: err pulses=%0d load/busy cycles=%0d, expected 1 and 0", errs, active);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    mode = 1; tog = 0; nid = 10'd77; nslot = 8'd5;
    @(negedge clk); start8 = 1;
    @(negedge clk); start8 = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (!(busy8 && en8 && !nv8)) begin errors++; $display("FAIL midrst_pre: busy=%b en=%b valid=%b, expected 1 1 0", busy8, en8, nv8); end
    #2 rst = 0;
    #1;
    checks++;
    if ({load8, en8, nv8, busy8, done8, err8, init8, ncs8, idx8} !== '0) begin
      errors++; $display("FAIL midrst_clear: outputs=%h, expected all 0", {load8, en8, nv8, busy8, done8, err8, init8, ncs8, idx8});
    end
    @(negedge clk); rst = 1;
    for (int l = 0; l < 14; l++) exp_ncs.push_back(8'(14 + l));
    run_slot(0, 1, -1);
    checks++;
    if (done_t < 0 || obs_ncs.size() != 14) begin errors++; $display("FAIL midrst_rerun: %0d values done_t=%0d, expected 14 and done", obs_ncs.size(), done_t); end
    for (int l = 0; l < 14; l++) begin
      e = exp_ncs.pop_front(); checks++;
      if (l >= obs_ncs.size() || obs_ncs[l] !== e) begin
        errors++; $display("FAIL midrst_ncs l=%0d: got %0d, expected %0d", l, obs_ncs[l], e);
      end
    end
  endtask

`ifdef NCS_CYC_SHIFT_EN
  task automatic test_cs();
    mode = 2; tog = 0; m0 = 4'd11; mcs = 4'd11;
    run_slot(0, 0, -1);
    checks++;
    if (obs_cs.size() != 14 || obs_cs[0] !== 4'd1 || obs_cs[13] !== 4'd1 || obs_ncs[0] !== 8'd255) begin
      errors++; $display("FAIL cs_277: cs=%0d ncs=%0d n=%0d, expected cs=1 ncs=255 n=14", obs_cs[0], obs_ncs[0], obs_cs.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_gold8();
    test_gold1();
    test_stub_consec("consec", -1);
    test_stub_toggle();
    test_err();
    test_stub_consec("ignore", 5);
    test_reset_mid();
    test_stub_consec("b2b_a", -1);
    test_stub_consec("b2b_b", -1);
`ifdef NCS_CYC_SHIFT_EN
    test_cs();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
